pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, width of program counter, bus and offsets.
REQ-002 Parameter STACK_DEPTH, default 8, number of return-address stack entries (power of two, >=2).
REQ-003 Parameter RESET_VECTOR, default 0, value loaded into the PC on reset.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 pc_enable  input  1  when 1, the mode is executed on the next rising clk; when 0, all state holds.
REQ-007 mode  input  3  operation: 0 INC, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 HOLD, 6-7 reserved.
REQ-008 cond  input  1  branch condition, used only by BRANCH.
REQ-009 bus  input  WIDTH  absolute target (JUMP, CALL) or two's-complement offset (BRANCH).
REQ-010 out  output  WIDTH  current program counter, registered.
REQ-011 stack_empty  output  1  return stack holds 0 entries.
REQ-012 stack_full  output  1  return stack holds STACK_DEPTH entries.
REQ-013 fault  output  1  sticky stack overflow/underflow flag.

Function
REQ-014 All updates occur on the rising clk edge with pc_enable=1; new out visible one cycle after that edge (latency 1).
REQ-015 pc_enable=0: out, stack contents, stack count and fault unchanged, whatever the mode.
REQ-016 INC: out <= out + 1, modulo 2^WIDTH (all-ones wraps to 0).
REQ-017 JUMP: out <= bus.
REQ-018 BRANCH, cond=1: out <= out + sign-extended bus, modulo 2^WIDTH; cond=0: behaves as INC.
REQ-019 CALL, stack not full: push out + 1 (modulo 2^WIDTH), out <= bus, count increments.
REQ-020 CALL, stack full: no push, out unchanged, fault <= 1.
REQ-021 RET, stack not empty: out <= most recently pushed entry, count decrements (LIFO).
REQ-022 RET, stack empty: out unchanged, stack unchanged, fault <= 1.
REQ-023 HOLD and reserved modes 6-7: out and stack unchanged; no fault.
REQ-024 stack_empty and stack_full are combinational decodes of the registered count; valid in the same cycle as the count.
REQ-025 fault, once set, remains 1 until reset; faults do not block subsequent valid operations.
REQ-026 Stack storage is registers; popped entries need not be cleared.
REQ-027 Stack count range 0..STACK_DEPTH; count never wraps.

Reset
REQ-028 rst=1 forces immediately, without waiting for clk: out=RESET_VECTOR, count=0, stack_empty=1, stack_full=0, fault=0.
REQ-029 rst asserted mid-operation (any mode, any count) discards the pending operation; stack entries need not be cleared.
REQ-030 While rst=1 no operation executes; first operation executes on the first rising clk with rst=0 and pc_enable=1.

Verification
REQ-031 Reset then pc_enable=1, mode=INC for 3 cycles -> out = 0, 1, 2, 3; stack_empty=1, fault=0.
REQ-032 out=0x0010, BRANCH bus=0xFFFC cond=1 -> out=0x000C; repeat with cond=0 -> out=0x000D.
REQ-033 out=0x0100, CALL bus=0x2000 -> out=0x2000, stack_empty=0; RET -> out=0x0101, stack_empty=1.
REQ-034 8 CALLs (depth 8) -> stack_full=1, fault=0; 9th CALL -> out unchanged, fault=1; 8 RETs unwind in reverse order, 9th RET -> out unchanged, fault stays 1.
REQ-035 out=0xFFFF, INC -> out=0x0000; pc_enable=0 with mode=JUMP bus=0x1234 -> out stays 0x0000.
REQ-036 Assert rst between clock edges during a CALL sequence -> out=RESET_VECTOR and stack_empty=1 before the next edge; fault=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer: increment, jump, relative branch, and call/return
// through a register-based return-address stack with a sticky fault flag.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 16,
    parameter int unsigned      STACK_DEPTH  = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_enable,
    input  logic [2:0]       mode,
    input  logic             cond,
    input  logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] out,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             fault
);

    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        MODE_INC    = 3'd0,
        MODE_JUMP   = 3'd1,
        MODE_BRANCH = 3'd2,
        MODE_CALL   = 3'd3,
        MODE_RET    = 3'd4,
        MODE_HOLD   = 3'd5
    } mode_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    logic             push;
    logic [PTR_W-1:0] pushIdx;
    logic [PTR_W-1:0] topIdx;
    logic [WIDTH-1:0] pcPlusOne;

    assign pushIdx     = cnt_q[PTR_W-1:0];
    assign topIdx      = PTR_W'(cnt_q - CNT_W'(1));
    assign pcPlusOne   = pc_q + WIDTH'(1);
    assign stack_empty = (cnt_q == '0);
    assign stack_full  = (cnt_q == CNT_W'(STACK_DEPTH));
    assign out         = pc_q;
    assign fault       = fault_q;

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        push    = 1'b0;
        if (pc_enable) begin
            case (mode)
                MODE_INC:    pc_d = pcPlusOne;
                MODE_JUMP:   pc_d = bus;
                // bus is already WIDTH bits, so two's-complement addition is the sign-extended add
                MODE_BRANCH: pc_d = cond ? (pc_q + bus) : pcPlusOne;
                MODE_CALL: begin
                    if (stack_full) begin
                        fault_d = 1'b1;
                    end else begin
                        push  = 1'b1;
                        pc_d  = bus;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MODE_RET: begin
                    if (stack_empty) begin
                        fault_d = 1'b1;
                    end else begin
                        pc_d  = stack_q[topIdx];
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Stack storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack_q[pushIdx] <= pcPlusOne;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (WIDTH=16, STACK_DEPTH=8, RESET_VECTOR=0).
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        pc_enable;
    logic [2:0]  mode;
    logic        cond;
    logic [15:0] bus;
    logic [15:0] out;
    logic        stack_empty;
    logic        stack_full;
    logic        fault;

    int checks;
    int failures;

    logic [15:0] retModel [8];
    logic [15:0] pcModel;

    pc_sequencer #(
        .WIDTH(16),
        .STACK_DEPTH(8),
        .RESET_VECTOR(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pc_enable(pc_enable),
        .mode(mode),
        .cond(cond),
        .bus(bus),
        .out(out),
        .stack_empty(stack_empty),
        .stack_full(stack_full),
        .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one operation, lets it execute on the next rising edge, returns 1 time unit later.
    task automatic applyStimulus(input logic en, input logic [2:0] m, input logic c, input logic [15:0] b);
        pc_enable = en;
        mode      = m;
        cond      = c;
        bus       = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        pc_enable = 1'b0;
        mode      = 3'd0;
        cond      = 1'b0;
        bus       = 16'h0000;

        #2;
        checkOutput("reset_out", 32'(out), 32'h0000);
        checkOutput("reset_empty", 32'(stack_empty), 32'd1);
        checkOutput("reset_full", 32'(stack_full), 32'd0);
        checkOutput("reset_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 3'd0, 1'b0, 16'h0000);
            checkOutput("inc_seq", 32'(out), 32'(i));
        end
        checkOutput("inc_empty", 32'(stack_empty), 32'd1);
        checkOutput("inc_fault", 32'(fault), 32'd0);

        applyStimulus(1'b1, 3'd1, 1'b0, 16'h0010);
        checkOutput("jump", 32'(out), 32'h0010);
        applyStimulus(1'b1, 3'd2, 1'b1, 16'hFFFC);
        checkOutput("branch_taken", 32'(out), 32'h000C);
        applyStimulus(1'b1, 3'd2, 1'b0, 16'hFFFC);
        checkOutput("branch_not_taken", 32'(out), 32'h000D);

        applyStimulus(1'b1, 3'd1, 1'b0, 16'h0100);
        applyStimulus(1'b1, 3'd3, 1'b0, 16'h2000);
        checkOutput("call_out", 32'(out), 32'h2000);
        checkOutput("call_empty", 32'(stack_empty), 32'd0);
        applyStimulus(1'b1, 3'd4, 1'b0, 16'h0000);
        checkOutput("ret_out", 32'(out), 32'h0101);
        checkOutput("ret_empty", 32'(stack_empty), 32'd1);

        applyStimulus(1'b1, 3'd5, 1'b0, 16'h9999);
        checkOutput("hold_out", 32'(out), 32'h0101);
        applyStimulus(1'b1, 3'd7, 1'b1, 16'h9999);
        checkOutput("reserved_out", 32'(out), 32'h0101);
        checkOutput("reserved_fault", 32'(fault), 32'd0);

        pcModel = 16'h0101;
        for (int i = 0; i < 8; i++) begin
            retModel[i] = pcModel + 16'h0001;
            pcModel     = 16'h1000 + 16'(i * 16);
            applyStimulus(1'b1, 3'd3, 1'b0, pcModel);
            checkOutput("fill_call_out", 32'(out), 32'(pcModel));
        end
        checkOutput("fill_full", 32'(stack_full), 32'd1);
        checkOutput("fill_fault", 32'(fault), 32'd0);

        applyStimulus(1'b1, 3'd3, 1'b0, 16'h5555);
        checkOutput("overflow_out", 32'(out), 32'h1070);
        checkOutput("overflow_fault", 32'(fault), 32'd1);
        checkOutput("overflow_full", 32'(stack_full), 32'd1);

        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, 3'd4, 1'b0, 16'h0000);
            checkOutput("unwind_out", 32'(out), 32'(retModel[i]));
        end
        checkOutput("unwind_empty", 32'(stack_empty), 32'd1);
        applyStimulus(1'b1, 3'd4, 1'b0, 16'h0000);
        checkOutput("underflow_out", 32'(out), 32'h0102);
        checkOutput("underflow_fault", 32'(fault), 32'd1);

        applyStimulus(1'b1, 3'd1, 1'b0, 16'hFFFF);
        applyStimulus(1'b1, 3'd0, 1'b0, 16'h0000);
        checkOutput("inc_wrap", 32'(out), 32'h0000);
        applyStimulus(1'b0, 3'd1, 1'b0, 16'h1234);
        checkOutput("disabled_jump", 32'(out), 32'h0000);
        applyStimulus(1'b0, 3'd3, 1'b0, 16'h1234);
        checkOutput("disabled_call_out", 32'(out), 32'h0000);
        checkOutput("disabled_call_empty", 32'(stack_empty), 32'd1);

        applyStimulus(1'b1, 3'd3, 1'b0, 16'h3000);
        applyStimulus(1'b1, 3'd3, 1'b0, 16'h4000);
        checkOutput("pre_reset_empty", 32'(stack_empty), 32'd0);
        pc_enable = 1'b1;
        mode      = 3'd3;
        bus       = 16'h5000;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset_out", 32'(out), 32'h0000);
        checkOutput("midreset_empty", 32'(stack_empty), 32'd1);
        checkOutput("midreset_fault", 32'(fault), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("held_in_reset", 32'(out), 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 3'd0, 1'b0, 16'h0000);
        checkOutput("post_reset_inc", 32'(out), 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
